hilo_capture_unit: RTL and testbench

- Sequential stage directly downstream of the 32x32 signed combinational multiplier (mul_32bit).
- Registers the operands that drive the multiplier and waits a fixed settle time for its 64-bit product.
- Then captures the product into the HI/LO register pair and exposes HI/LO to the datapath.
- Also supports direct HI/LO writes (mthi/mtlo) and a start/busy/done handshake to the control unit.

---
 rtl/hilo_capture_unit_if.sv | 35 +++
 rtl/hilo_capture_unit.sv | 113 +++++++++++
 tb/tb_hilo_capture_unit.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_capture_unit_if.sv
// hilo_capture_unit_if
//   Bundles the operand, product, HI/LO and handshake signals of the HI/LO
//   capture stage.
//   master : control unit / datapath / multiplier side
//   slave  : hilo_capture_unit
//   Signals: start, op_a, op_b, mul_a, mul_b, mul_product, hi_in, lo_in,
//            hi_we, lo_we, busy, done, hi_out, lo_out
interface hilo_capture_unit_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   hi_in;
  logic [WIDTH-1:0]   lo_in;
  logic               hi_we;
  logic               lo_we;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   hi_out;
  logic [WIDTH-1:0]   lo_out;

  modport master (
    output start, op_a, op_b, mul_product, hi_in, lo_in, hi_we, lo_we,
    input  mul_a, mul_b, busy, done, hi_out, lo_out
  );

  modport slave (
    input  start, op_a, op_b, mul_product, hi_in, lo_in, hi_we, lo_we,
    output mul_a, mul_b, busy, done, hi_out, lo_out
  );
endinterface

// File: rtl/hilo_capture_unit.sv
// hilo_capture_unit
//   Registers the operands feeding the combinational multiplier, waits
//   SETTLE_CYCLES edges for the product to settle, then captures it into
//   the HI/LO pair. HI/LO can also be written directly while idle.
//   Ports:
//     clock    rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      hilo_capture_unit_if.slave (operands, product, HI/LO, handshake)
//
//   state  | meaning
//   IDLE   | waiting for start; direct HI/LO writes honoured
//   SETTLE | operands held on mul_a/mul_b, counting down to product capture
module hilo_capture_unit #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input logic                clock,
  input logic                reset_n,
  hilo_capture_unit_if.slave bus
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             capture;
  logic             hi_wr;
  logic             lo_wr;
  logic [WIDTH-1:0] mul_a_q;
  logic [WIDTH-1:0] mul_b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    hi_wr     = 1'b0;
    lo_wr     = 1'b0;
    case (state)
      IDLE: begin
        hi_wr = bus.hi_we;
        lo_wr = bus.lo_we;
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        // Terminal count: product has settled, capture on this edge.
        if (cnt == CW'(1)) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= capture;

      if (accept) begin
        mul_a_q <= bus.op_a;
        mul_b_q <= bus.op_b;
        cnt     <= CW'(SETTLE_CYCLES);
      end else if (capture) begin
        cnt <= '0;
      end else if (state == SETTLE) begin
        cnt <= cnt - 1'b1;
      end

      // Product is only looked at on the capture edge, so a floating
      // multiplier output in between never reaches HI/LO.
      if (capture) begin
        hi_q <= bus.mul_product[2*WIDTH-1:WIDTH];
        lo_q <= bus.mul_product[WIDTH-1:0];
      end else begin
        if (hi_wr) hi_q <= bus.hi_in;
        if (lo_wr) lo_q <= bus.lo_in;
      end
    end
  end

  assign bus.mul_a  = mul_a_q;
  assign bus.mul_b  = mul_b_q;
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;
  assign bus.busy   = (state == SETTLE);
  assign bus.done   = done_q;

endmodule

// File: tb/tb_hilo_capture_unit.sv
// tb_hilo_capture_unit
//   Two instances: SETTLE_CYCLES=4 (main) and SETTLE_CYCLES=1 (short settle).
//   A signed 32x32 multiply model stands in for mul_32bit as product source.
module tb_hilo_capture_unit;
  localparam int W = 32;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  hilo_capture_unit_if #(.WIDTH(W)) u1_if ();
  hilo_capture_unit_if #(.WIDTH(W)) u2_if ();

  hilo_capture_unit #(.WIDTH(W), .SETTLE_CYCLES(4)) dut1 (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (u1_if.slave)
  );

  hilo_capture_unit #(.WIDTH(W), .SETTLE_CYCLES(1)) dut2 (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (u2_if.slave)
  );

  // Signed product: sign-extend both operands to 2W bits, keep low 2W bits.
  assign u1_if.mul_product = {{W{u1_if.mul_a[W-1]}}, u1_if.mul_a} * {{W{u1_if.mul_b[W-1]}}, u1_if.mul_b};
  assign u2_if.mul_product = {{W{u2_if.mul_a[W-1]}}, u2_if.mul_a} * {{W{u2_if.mul_b[W-1]}}, u2_if.mul_b};

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t sb1[$];
  exp_t sb2[$];
  vec_t vecs[7];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitors: every done pulse must match the oldest outstanding multiply.
  always @(negedge clock) begin : mon1
    exp_t e;
    if (reset_n && u1_if.done === 1'b1) begin
      if (sb1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL dut1_unexpected_done: done=1, expected no done pulse");
      end else begin
        e = sb1.pop_front();
        chk("dut1_sb_hi", u1_if.hi_out, e.hi);
        chk("dut1_sb_lo", u1_if.lo_out, e.lo);
      end
    end
  end

  always @(negedge clock) begin : mon2
    exp_t e;
    if (reset_n && u2_if.done === 1'b1) begin
      if (sb2.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL dut2_unexpected_done: done=1, expected no done pulse");
      end else begin
        e = sb2.pop_front();
        chk("dut2_sb_hi", u2_if.hi_out, e.hi);
        chk("dut2_sb_lo", u2_if.lo_out, e.lo);
      end
    end
  end

  // One full multiply on dut1 with cycle-by-cycle busy/done checks.
  task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] hi, input logic [W-1:0] lo);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    u1_if.start = 1'b1;
    u1_if.op_a  = a;
    u1_if.op_b  = b;
    sb1.push_back(e);
    tick();
    u1_if.start = 1'b0;
    chk("vec_mul_a", u1_if.mul_a, a);
    chk("vec_mul_b", u1_if.mul_b, b);
    chk("vec_busy_e0", W'(u1_if.busy), W'(1));
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("vec_busy_mid", W'(u1_if.busy), W'(1));
      chk("vec_done_mid", W'(u1_if.done), W'(0));
    end
    tick();
    chk("vec_busy_cap", W'(u1_if.busy), W'(0));
    chk("vec_done_cap", W'(u1_if.done), W'(1));
    chk("vec_hi", u1_if.hi_out, hi);
    chk("vec_lo", u1_if.lo_out, lo);
    tick();
    chk("vec_done_after", W'(u1_if.done), W'(0));
  endtask

  initial begin
    exp_t e;
    vecs[0] = '{a: 32'd16,         b: 32'd10,         hi: 32'h00000000, lo: 32'd160};
    vecs[1] = '{a: 32'hFFFFFFFD,   b: 32'd7,          hi: 32'hFFFFFFFF, lo: 32'hFFFFFFEB};
    vecs[2] = '{a: 32'h7FFFFFFF,   b: 32'h7FFFFFFF,   hi: 32'h3FFFFFFF, lo: 32'h00000001};
    vecs[3] = '{a: 32'h80000000,   b: 32'h80000000,   hi: 32'h40000000, lo: 32'h00000000};
    vecs[4] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   hi: 32'h00000000, lo: 32'h00000001};
    vecs[5] = '{a: 32'h00000000,   b: 32'h12345678,   hi: 32'h00000000, lo: 32'h00000000};
    vecs[6] = '{a: 32'h80000000,   b: 32'h00000001,   hi: 32'hFFFFFFFF, lo: 32'h80000000};

    u1_if.start = 1'b0; u1_if.op_a = '0; u1_if.op_b = '0;
    u1_if.hi_in = '0;   u1_if.lo_in = '0; u1_if.hi_we = 1'b0; u1_if.lo_we = 1'b0;
    u2_if.start = 1'b0; u2_if.op_a = '0; u2_if.op_b = '0;
    u2_if.hi_in = '0;   u2_if.lo_in = '0; u2_if.hi_we = 1'b0; u2_if.lo_we = 1'b0;
    reset_n = 1'b0;

    // Reset state
    tick();
    chk("rst_mul_a", u1_if.mul_a, '0);
    chk("rst_mul_b", u1_if.mul_b, '0);
    chk("rst_hi", u1_if.hi_out, '0);
    chk("rst_lo", u1_if.lo_out, '0);
    chk("rst_busy", W'(u1_if.busy), W'(0));
    chk("rst_done", W'(u1_if.done), W'(0));
    chk("rst2_busy", W'(u2_if.busy), W'(0));
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // Table-driven multiplies
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
    end

    // start while busy is ignored; start in done cycle is accepted
    e.hi = 32'h0; e.lo = 32'd160;
    sb1.push_back(e);
    u1_if.start = 1'b1; u1_if.op_a = 32'd16; u1_if.op_b = 32'd10;
    tick();                          // edge 0
    u1_if.start = 1'b0;
    tick();                          // edge 1
    u1_if.start = 1'b1; u1_if.op_a = 32'd2; u1_if.op_b = 32'd2;
    tick();                          // edge 2: ignored
    u1_if.start = 1'b0;
    chk("ign_mul_a", u1_if.mul_a, 32'd16);
    tick();                          // edge 3
    tick();                          // edge 4: capture
    chk("ign_done", W'(u1_if.done), W'(1));
    chk("ign_lo", u1_if.lo_out, 32'd160);
    chk("ign_mul_a_hold", u1_if.mul_a, 32'd16);
    e.hi = 32'h0; e.lo = 32'd4;
    sb1.push_back(e);
    u1_if.start = 1'b1; u1_if.op_a = 32'd2; u1_if.op_b = 32'd2;
    tick();                          // edge 5: accepted in done cycle
    u1_if.start = 1'b0;
    chk("b2b_busy", W'(u1_if.busy), W'(1));
    chk("b2b_mul_a", u1_if.mul_a, 32'd2);
    for (int k = 0; k < 3; k++) tick();
    tick();                          // edge 9
    chk("b2b_done", W'(u1_if.done), W'(1));
    chk("b2b_lo", u1_if.lo_out, 32'd4);
    tick();

    // Direct writes in IDLE, ignored while busy
    u1_if.hi_we = 1'b1; u1_if.hi_in = 32'hDEADBEEF;
    tick();
    u1_if.hi_we = 1'b0;
    chk("mthi_hi", u1_if.hi_out, 32'hDEADBEEF);
    chk("mthi_lo_unch", u1_if.lo_out, 32'd4);
    e.hi = 32'h0; e.lo = 32'd160;
    sb1.push_back(e);
    u1_if.start = 1'b1; u1_if.op_a = 32'd16; u1_if.op_b = 32'd10;
    tick();
    u1_if.start = 1'b0;
    u1_if.lo_we = 1'b1; u1_if.lo_in = 32'h12345678;
    tick();
    u1_if.lo_we = 1'b0;
    chk("mtlo_busy_ign", u1_if.lo_out, 32'd4);
    chk("mthi_kept", u1_if.hi_out, 32'hDEADBEEF);
    tick(); tick(); tick();
    chk("mtlo_overwr_lo", u1_if.lo_out, 32'd160);
    chk("mtlo_overwr_hi", u1_if.hi_out, 32'h0);
    tick();

    // start together with direct writes: write lands, capture overwrites
    e.hi = 32'h0; e.lo = 32'd25;
    sb1.push_back(e);
    u1_if.start = 1'b1; u1_if.op_a = 32'd5; u1_if.op_b = 32'd5;
    u1_if.hi_we = 1'b1; u1_if.hi_in = 32'hAAAA5555;
    u1_if.lo_we = 1'b1; u1_if.lo_in = 32'h0F0F0F0F;
    tick();
    u1_if.start = 1'b0; u1_if.hi_we = 1'b0; u1_if.lo_we = 1'b0;
    chk("sw_hi", u1_if.hi_out, 32'hAAAA5555);
    chk("sw_lo", u1_if.lo_out, 32'h0F0F0F0F);
    for (int k = 0; k < 3; k++) tick();
    tick();
    chk("sw_cap_hi", u1_if.hi_out, 32'h0);
    chk("sw_cap_lo", u1_if.lo_out, 32'd25);
    tick();

    // Asynchronous reset mid-multiply
    e.hi = 32'h0; e.lo = 32'd160;
    sb1.push_back(e);
    u1_if.start = 1'b1; u1_if.op_a = 32'd16; u1_if.op_b = 32'd10;
    tick();
    u1_if.start = 1'b0;
    tick();
    #3;
    reset_n = 1'b0;
    sb1.delete();
    #1;
    chk("arst_mul_a", u1_if.mul_a, '0);
    chk("arst_lo", u1_if.lo_out, '0);
    chk("arst_busy", W'(u1_if.busy), W'(0));
    chk("arst_lo2", u2_if.lo_out, '0);
    #4;
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("arst_idle_busy", W'(u1_if.busy), W'(0));
    end
    run_vec(32'd16, 32'd10, 32'h0, 32'd160);

    // SETTLE_CYCLES=1 instance, back-to-back
    e.hi = 32'h0; e.lo = 32'd25;
    sb2.push_back(e);
    u2_if.start = 1'b1; u2_if.op_a = 32'd5; u2_if.op_b = 32'd5;
    tick();
    u2_if.start = 1'b0;
    chk("s1_busy", W'(u2_if.busy), W'(1));
    chk("s1_done0", W'(u2_if.done), W'(0));
    tick();
    chk("s1_busy_cap", W'(u2_if.busy), W'(0));
    chk("s1_done", W'(u2_if.done), W'(1));
    chk("s1_lo", u2_if.lo_out, 32'd25);
    e.hi = 32'hFFFFFFFF; e.lo = 32'hFFFFFFF4;
    sb2.push_back(e);
    u2_if.start = 1'b1; u2_if.op_a = 32'd3; u2_if.op_b = 32'hFFFFFFFC;
    tick();
    u2_if.start = 1'b0;
    chk("s1_b2b_busy", W'(u2_if.busy), W'(1));
    tick();
    chk("s1_b2b_done", W'(u2_if.done), W'(1));
    chk("s1_b2b_hi", u2_if.hi_out, 32'hFFFFFFFF);
    chk("s1_b2b_lo", u2_if.lo_out, 32'hFFFFFFF4);
    tick();
    chk("s1_done_after", W'(u2_if.done), W'(0));

    tick(); tick();
    chk("sb1_drained", W'(sb1.size()), W'(0));
    chk("sb2_drained", W'(sb2.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
